// File: rtl/clock_pkg.sv
// Shared BCD limits, FSM encoding and digit/field checks for the HH:MM:SS time keeper.
package clock_pkg;

    localparam logic [7:0]  SEC_MAX  = 8'h59;
    localparam logic [7:0]  MIN_MAX  = 8'h59;
    localparam logic [7:0]  HR24_MAX = 8'h23;
    localparam logic [7:0]  HR12_MIN = 8'h01;
    localparam logic [7:0]  HR12_MAX = 8'h12;

    typedef enum logic {
        ST_RUN  = 1'b0,
        ST_HOLD = 1'b1
    } state_t;

    function automatic logic bcd_valid(input logic [3:0] digit);
        return digit <= 4'd9;
    endfunction

    // Once both digits are legal BCD, a plain byte compare orders fields numerically.
    function automatic logic field_in_range(input logic [7:0] field,
                                            input logic [7:0] lo,
                                            input logic [7:0] hi);
        return bcd_valid(field[7:4]) && bcd_valid(field[3:0]) && (field >= lo) && (field <= hi);
    endfunction

endpackage

// File: rtl/bcd_field_counter.sv
// Two-digit packed-BCD field counter with synchronous load, wrapping from its top value to WRAP_VAL.
module bcd_field_counter #(
    parameter logic [3:0] TENS_MAX         = 4'd5,
    parameter logic [3:0] UNITS_MAX_AT_TOP = 4'd9,
    parameter logic [7:0] WRAP_VAL         = 8'h00,
    parameter logic [7:0] RESET_VAL        = 8'h00
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       inc,
    input  logic       load,
    input  logic [7:0] load_val,
    output logic [7:0] val,
    output logic       carry_out
);

    localparam logic [7:0] TOP = {TENS_MAX, UNITS_MAX_AT_TOP};

    logic [7:0] r_val;
    logic [7:0] w_next;

    always_comb begin
        w_next = r_val;
        if (r_val == TOP) begin
            w_next = WRAP_VAL;
        end else if (r_val[3:0] == 4'd9) begin
            w_next = {r_val[7:4] + 4'd1, 4'd0};
        end else begin
            w_next = {r_val[7:4], r_val[3:0] + 4'd1};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_val <= RESET_VAL;
        end else if (load) begin
            r_val <= load_val;
        end else if (inc) begin
            r_val <= w_next;
        end
    end

    assign val       = r_val;
    assign carry_out = inc && !load && (r_val == TOP);

endmodule

// File: rtl/time_keeper.sv
// HH:MM:SS packed-BCD time keeper advanced by the 1 Hz enable, with a valid/ready time-load port,
// a 12/24 hour mode and a one-cycle end-of-day pulse.
module time_keeper
    import clock_pkg::*;
#(
    parameter int HOURS_PER_DAY = 24,
    parameter int LOAD_HOLD     = 1
) (
    input  logic        sys_clk,
    input  logic        rst_n,
    input  logic        clk_1hz_en,
    input  logic        run_en,
    input  logic        set_valid,
    output logic        set_ready,
    input  logic [23:0] set_time,
    input  logic        set_pm,
    output logic        set_err,
    output logic [23:0] time_bcd,
    output logic        pm,
    output logic        sec_pulse,
    output logic        day_wrap
);

    localparam bit         IS_12H    = (HOURS_PER_DAY == 12);
    localparam logic [7:0] HR_MIN    = IS_12H ? HR12_MIN : 8'h00;
    localparam logic [7:0] HR_MAX    = IS_12H ? HR12_MAX : HR24_MAX;
    localparam logic [7:0] HR_WRAP   = IS_12H ? 8'h01 : 8'h00;
    localparam logic [7:0] HR_RESET  = IS_12H ? 8'h12 : 8'h00;
    localparam logic [1:0] HOLD_LAST = 2'(LOAD_HOLD - 1);

    state_t     r_state;
    logic       r_ready;
    logic [1:0] r_hold_cnt;
    logic       r_set_err;
    logic       r_pm;
    logic       r_sec_pulse;
    logic       r_day_wrap;

    logic       w_accept;
    logic       w_time_ok;
    logic       w_load_ok;
    logic       w_tick;
    logic [7:0] w_ss;
    logic [7:0] w_mm;
    logic [7:0] w_hh;
    logic       w_ss_carry;
    logic       w_mm_carry;
    logic       w_hh_carry;
    logic       w_pm_toggle;

    assign w_accept  = set_valid && r_ready;
    assign w_time_ok = field_in_range(set_time[23:16], HR_MIN, HR_MAX) &&
                       field_in_range(set_time[15:8],  8'h00,  MIN_MAX) &&
                       field_in_range(set_time[7:0],   8'h00,  SEC_MAX);
    assign w_load_ok = w_accept && w_time_ok;
    // Any accepted load, even a rejected one, swallows a coincident tick.
    assign w_tick    = clk_1hz_en && run_en && !w_accept;

    bcd_field_counter #(
        .TENS_MAX        (SEC_MAX[7:4]),
        .UNITS_MAX_AT_TOP(SEC_MAX[3:0]),
        .WRAP_VAL        (8'h00),
        .RESET_VAL       (8'h00)
    ) u_ss (
        .clk      (sys_clk),
        .rst_n    (rst_n),
        .inc      (w_tick),
        .load     (w_load_ok),
        .load_val (set_time[7:0]),
        .val      (w_ss),
        .carry_out(w_ss_carry)
    );

    bcd_field_counter #(
        .TENS_MAX        (MIN_MAX[7:4]),
        .UNITS_MAX_AT_TOP(MIN_MAX[3:0]),
        .WRAP_VAL        (8'h00),
        .RESET_VAL       (8'h00)
    ) u_mm (
        .clk      (sys_clk),
        .rst_n    (rst_n),
        .inc      (w_ss_carry),
        .load     (w_load_ok),
        .load_val (set_time[15:8]),
        .val      (w_mm),
        .carry_out(w_mm_carry)
    );

    bcd_field_counter #(
        .TENS_MAX        (HR_MAX[7:4]),
        .UNITS_MAX_AT_TOP(HR_MAX[3:0]),
        .WRAP_VAL        (HR_WRAP),
        .RESET_VAL       (HR_RESET)
    ) u_hh (
        .clk      (sys_clk),
        .rst_n    (rst_n),
        .inc      (w_mm_carry),
        .load     (w_load_ok),
        .load_val (set_time[23:16]),
        .val      (w_hh),
        .carry_out(w_hh_carry)
    );

    // In 12 h mode am/pm flips on 11:59:59 -> 12:00:00, not on the 12 -> 01 hour wrap.
    assign w_pm_toggle = IS_12H && w_mm_carry && (w_hh == 8'h11);

    always_ff @(posedge sys_clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= ST_RUN;
            r_ready    <= 1'b1;
            r_hold_cnt <= 2'd0;
            r_set_err  <= 1'b0;
        end else begin
            r_set_err <= w_accept && !w_time_ok;
            case (r_state)
                ST_RUN: begin
                    if (w_accept) begin
                        r_state    <= ST_HOLD;
                        r_ready    <= 1'b0;
                        r_hold_cnt <= HOLD_LAST;
                    end
                end
                ST_HOLD: begin
                    if (r_hold_cnt == 2'd0) begin
                        r_state <= ST_RUN;
                        r_ready <= 1'b1;
                    end else begin
                        r_hold_cnt <= r_hold_cnt - 2'd1;
                    end
                end
                default: begin
                    r_state <= ST_RUN;
                    r_ready <= 1'b1;
                end
            endcase
        end
    end

    always_ff @(posedge sys_clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pm        <= 1'b0;
            r_sec_pulse <= 1'b0;
            r_day_wrap  <= 1'b0;
        end else begin
            r_sec_pulse <= w_tick;
            if (w_load_ok) begin
                r_pm <= IS_12H && set_pm;
            end else if (w_pm_toggle) begin
                r_pm <= !r_pm;
            end
            // A 12 h day ends when pm falls; a 24 h day ends on the hour counter wrap.
            r_day_wrap <= IS_12H ? (w_pm_toggle && r_pm) : w_hh_carry;
        end
    end

    assign set_ready = r_ready;
    assign set_err   = r_set_err;
    assign time_bcd  = {w_hh, w_mm, w_ss};
    assign pm        = r_pm;
    assign sec_pulse = r_sec_pulse;
    assign day_wrap  = r_day_wrap;

endmodule

// File: tb/tb_time_keeper.sv
// Bench for time_keeper: a 24 h instance (LOAD_HOLD=1) and a 12 h instance (LOAD_HOLD=2) share inputs
// and are checked every cycle against a seconds-of-day reference model.
module tb_time_keeper;

    typedef struct {
        logic        setValid;
        logic [23:0] setTime;
        logic        setPm;
        logic        tick;
        logic        run;
        logic [23:0] expTime24;
        logic        expWrap24;
        logic        expErr24;
        logic        expReady24;
    } vec_t;

    localparam int DAY_SECS = 86400;

    logic        sysClk = 1'b0;
    logic        rstN;
    logic        clk1hz;
    logic        runEn;
    logic        setValid;
    logic [23:0] setTime;
    logic        setPm;

    logic        ready24, err24, pm24, sp24, wrap24;
    logic [23:0] time24;
    logic        ready12, err12, pm12, sp12, wrap12;
    logic [23:0] time12;

    int nCompared   = 0;
    int nMismatched = 0;

    int mSecs  [2];
    int mHold  [2];
    bit mReady [2];
    bit mErr   [2];
    bit mSp    [2];
    bit mWrap  [2];
    int holdLen[2] = '{1, 2};

    vec_t tbl[12];

    always #5 sysClk = ~sysClk;

    time_keeper #(.HOURS_PER_DAY(24), .LOAD_HOLD(1)) u24 (
        .sys_clk   (sysClk),
        .rst_n     (rstN),
        .clk_1hz_en(clk1hz),
        .run_en    (runEn),
        .set_valid (setValid),
        .set_ready (ready24),
        .set_time  (setTime),
        .set_pm    (setPm),
        .set_err   (err24),
        .time_bcd  (time24),
        .pm        (pm24),
        .sec_pulse (sp24),
        .day_wrap  (wrap24)
    );

    time_keeper #(.HOURS_PER_DAY(12), .LOAD_HOLD(2)) u12 (
        .sys_clk   (sysClk),
        .rst_n     (rstN),
        .clk_1hz_en(clk1hz),
        .run_en    (runEn),
        .set_valid (setValid),
        .set_ready (ready12),
        .set_time  (setTime),
        .set_pm    (setPm),
        .set_err   (err12),
        .time_bcd  (time12),
        .pm        (pm12),
        .sec_pulse (sp12),
        .day_wrap  (wrap12)
    );

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation time limit reached, got timeout required completion");
        $fatal(1, "[TB] watchdog expired");
    end

    function automatic logic [7:0] toBcd(input int v);
        return {4'(v / 10), 4'(v % 10)};
    endfunction

    function automatic int digitAt(input logic [23:0] t, input int idx);
        logic [3:0] d;
        d = t[23 - 4 * idx -: 4];
        return int'(d);
    endfunction

    function automatic logic timeValid(input logic [23:0] t, input bit is12);
        int h, m, s;
        for (int i = 0; i < 6; i++) begin
            if (digitAt(t, i) > 9) return 1'b0;
        end
        h = digitAt(t, 0) * 10 + digitAt(t, 1);
        m = digitAt(t, 2) * 10 + digitAt(t, 3);
        s = digitAt(t, 4) * 10 + digitAt(t, 5);
        if (m > 59 || s > 59) return 1'b0;
        if (is12) return (h >= 1 && h <= 12);
        return (h <= 23);
    endfunction

    function automatic int toSecs(input logic [23:0] t, input bit pmIn, input bit is12);
        int h, m, s;
        h = digitAt(t, 0) * 10 + digitAt(t, 1);
        m = digitAt(t, 2) * 10 + digitAt(t, 3);
        s = digitAt(t, 4) * 10 + digitAt(t, 5);
        if (is12) h = (h % 12) + (pmIn ? 12 : 0);
        return h * 3600 + m * 60 + s;
    endfunction

    // Returns {pm, HH, MM, SS} as the display should show seconds-of-day in the given mode.
    function automatic logic [24:0] expView(input int secs, input bit is12);
        int h24, h;
        bit pmv;
        h24 = secs / 3600;
        h   = h24;
        pmv = 1'b0;
        if (is12) begin
            pmv = (h24 >= 12);
            h   = h24 % 12;
            if (h == 0) h = 12;
        end
        return {pmv, toBcd(h), toBcd((secs / 60) % 60), toBcd(secs % 60)};
    endfunction

    task automatic modelReset();
        for (int d = 0; d < 2; d++) begin
            mSecs[d]  = 0;
            mHold[d]  = 0;
            mReady[d] = 1'b1;
            mErr[d]   = 1'b0;
            mSp[d]    = 1'b0;
            mWrap[d]  = 1'b0;
        end
    endtask

    task automatic modelEdge();
        bit accept;
        if (!rstN) begin
            modelReset();
            return;
        end
        for (int d = 0; d < 2; d++) begin
            accept   = setValid && mReady[d];
            mErr[d]  = 1'b0;
            mSp[d]   = 1'b0;
            mWrap[d] = 1'b0;
            if (accept) begin
                if (timeValid(setTime, d == 1)) mSecs[d] = toSecs(setTime, setPm, d == 1);
                else mErr[d] = 1'b1;
                mReady[d] = 1'b0;
                mHold[d]  = holdLen[d];
            end else begin
                if (clk1hz && runEn) begin
                    mSp[d] = 1'b1;
                    if (mSecs[d] == DAY_SECS - 1) begin
                        mSecs[d] = 0;
                        mWrap[d] = 1'b1;
                    end else begin
                        mSecs[d] = mSecs[d] + 1;
                    end
                end
                if (!mReady[d]) begin
                    mHold[d] = mHold[d] - 1;
                    if (mHold[d] == 0) mReady[d] = 1'b1;
                end
            end
        end
    endtask

    task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
        nCompared++;
        if (act !== exp) begin
            nMismatched++;
            $display("[TB] FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic checkOutput();
        logic [24:0] e0, e1;
        e0 = expView(mSecs[0], 1'b0);
        e1 = expView(mSecs[1], 1'b1);
        cmp("u24.time_bcd",  time24,  e0[23:0]);
        cmp("u24.pm",        pm24,    e0[24]);
        cmp("u24.set_ready", ready24, mReady[0]);
        cmp("u24.set_err",   err24,   mErr[0]);
        cmp("u24.sec_pulse", sp24,    mSp[0]);
        cmp("u24.day_wrap",  wrap24,  mWrap[0]);
        cmp("u12.time_bcd",  time12,  e1[23:0]);
        cmp("u12.pm",        pm12,    e1[24]);
        cmp("u12.set_ready", ready12, mReady[1]);
        cmp("u12.set_err",   err12,   mErr[1]);
        cmp("u12.sec_pulse", sp12,    mSp[1]);
        cmp("u12.day_wrap",  wrap12,  mWrap[1]);
    endtask

    // Called just after a falling edge: drive, take one rising edge, then check on the next falling edge.
    task automatic applyStimulus(input logic v, input logic [23:0] t, input logic p,
                                 input logic tick, input logic run);
        setValid = v;
        setTime  = t;
        setPm    = p;
        clk1hz   = tick;
        runEn    = run;
        @(posedge sysClk);
        modelEdge();
        @(negedge sysClk);
        checkOutput();
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) applyStimulus(1'b0, 24'h0, 1'b0, 1'b0, 1'b1);
    endtask

    task automatic checkResetValues(input string tag);
        cmp({tag, " u24.time_bcd"},  time24,  24'h000000);
        cmp({tag, " u12.time_bcd"},  time12,  24'h120000);
        cmp({tag, " u12.pm"},        pm12,    1'b0);
        cmp({tag, " u24.set_ready"}, ready24, 1'b1);
        cmp({tag, " u12.set_ready"}, ready12, 1'b1);
        cmp({tag, " u24.sec_pulse"}, sp24,    1'b0);
        cmp({tag, " u12.day_wrap"},  wrap12,  1'b0);
        cmp({tag, " u24.set_err"},   err24,   1'b0);
    endtask

    initial begin
        int pulses, wraps;
        logic [23:0] rt;
        logic [23:0] frozen24;

        tbl[0]  = '{1'b1, 24'h235958, 1'b0, 1'b0, 1'b1, 24'h235958, 1'b0, 1'b0, 1'b0};
        tbl[1]  = '{1'b0, 24'h000000, 1'b0, 1'b1, 1'b1, 24'h235959, 1'b0, 1'b0, 1'b1};
        tbl[2]  = '{1'b0, 24'h000000, 1'b0, 1'b1, 1'b1, 24'h000000, 1'b1, 1'b0, 1'b1};
        tbl[3]  = '{1'b0, 24'h000000, 1'b0, 1'b0, 1'b1, 24'h000000, 1'b0, 1'b0, 1'b1};
        tbl[4]  = '{1'b1, 24'h12341A, 1'b0, 1'b0, 1'b1, 24'h000000, 1'b0, 1'b1, 1'b0};
        tbl[5]  = '{1'b0, 24'h000000, 1'b0, 1'b0, 1'b1, 24'h000000, 1'b0, 1'b0, 1'b1};
        tbl[6]  = '{1'b1, 24'h100000, 1'b0, 1'b1, 1'b1, 24'h100000, 1'b0, 1'b0, 1'b0};
        tbl[7]  = '{1'b0, 24'h000000, 1'b0, 1'b1, 1'b1, 24'h100001, 1'b0, 1'b0, 1'b1};
        tbl[8]  = '{1'b1, 24'h245959, 1'b0, 1'b0, 1'b1, 24'h100001, 1'b0, 1'b1, 1'b0};
        tbl[9]  = '{1'b0, 24'h000000, 1'b0, 1'b1, 1'b0, 24'h100001, 1'b0, 1'b0, 1'b1};
        tbl[10] = '{1'b1, 24'h000000, 1'b0, 1'b1, 1'b0, 24'h000000, 1'b0, 1'b0, 1'b0};
        tbl[11] = '{1'b0, 24'h000000, 1'b0, 1'b1, 1'b1, 24'h000001, 1'b0, 1'b0, 1'b1};

        rstN     = 1'b0;
        clk1hz   = 1'b0;
        runEn    = 1'b1;
        setValid = 1'b0;
        setTime  = 24'h0;
        setPm    = 1'b0;
        modelReset();
        repeat (3) @(negedge sysClk);
        checkResetValues("reset");
        rstN = 1'b1;
        idle(1);

        $display("[TB] 60 ticks in 24 h mode");
        pulses = 0;
        wraps  = 0;
        for (int i = 0; i < 120; i++) begin
            applyStimulus(1'b0, 24'h0, 1'b0, (i % 2) == 0, 1'b1);
            if (sp24 === 1'b1) pulses++;
            if (wrap24 === 1'b1) wraps++;
        end
        cmp("60ticks time", time24, 24'h000100);
        cmp("60ticks pulse count", pulses, 60);
        cmp("60ticks wrap count", wraps, 0);

        $display("[TB] table vectors");
        for (int i = 0; i < 12; i++) begin
            applyStimulus(tbl[i].setValid, tbl[i].setTime, tbl[i].setPm, tbl[i].tick, tbl[i].run);
            cmp($sformatf("tbl[%0d] time", i),  time24,  tbl[i].expTime24);
            cmp($sformatf("tbl[%0d] wrap", i),  wrap24,  tbl[i].expWrap24);
            cmp($sformatf("tbl[%0d] err", i),   err24,   tbl[i].expErr24);
            cmp($sformatf("tbl[%0d] ready", i), ready24, tbl[i].expReady24);
        end

        $display("[TB] 12 h rollover sequences");
        idle(3);
        applyStimulus(1'b1, 24'h115959, 1'b1, 1'b0, 1'b1);
        idle(2);
        applyStimulus(1'b0, 24'h0, 1'b0, 1'b1, 1'b1);
        cmp("12h midnight time", time12, 24'h120000);
        cmp("12h midnight pm", pm12, 1'b0);
        cmp("12h midnight wrap", wrap12, 1'b1);
        cmp("24h noon no wrap", wrap24, 1'b0);
        idle(1);
        cmp("12h wrap one cycle", wrap12, 1'b0);
        applyStimulus(1'b1, 24'h125959, 1'b0, 1'b0, 1'b1);
        idle(2);
        applyStimulus(1'b0, 24'h0, 1'b0, 1'b1, 1'b1);
        cmp("12h 12->01 time", time12, 24'h010000);
        cmp("12h 12->01 no wrap", wrap12, 1'b0);

        $display("[TB] freeze with run_en low");
        frozen24 = time24;
        pulses   = 0;
        for (int i = 0; i < 5; i++) begin
            applyStimulus(1'b0, 24'h0, 1'b0, 1'b1, 1'b0);
            if (sp24 === 1'b1) pulses++;
        end
        cmp("freeze time", time24, expView(mSecs[0], 1'b0) & 25'h0FFFFFF);
        cmp("freeze pulses", pulses, 0);
        frozen24 = frozen24;

        $display("[TB] randomized traffic");
        for (int i = 0; i < 500; i++) begin
            case ($urandom_range(0, 3))
                0:       rt = $urandom();
                1:       rt = {8'h23 - 8'($urandom_range(0, 1) * 8'h12), 8'h59, toBcd($urandom_range(55, 59))};
                default: rt = {toBcd($urandom_range(1, 12)), toBcd($urandom_range(0, 59)),
                               toBcd($urandom_range(0, 59))};
            endcase
            applyStimulus($urandom_range(0, 5) == 0, rt, 1'($urandom()),
                          $urandom_range(0, 1) == 1, $urandom_range(0, 7) != 0);
        end

        $display("[TB] asynchronous reset mid-run");
        applyStimulus(1'b1, 24'h235959, 1'b1, 1'b1, 1'b1);
        setValid = 1'b0;
        clk1hz   = 1'b1;
        @(posedge sysClk);
        modelEdge();
        #2;
        rstN = 1'b0;
        #1;
        checkResetValues("async reset");
        modelReset();
        @(negedge sysClk);
        applyStimulus(1'b0, 24'h0, 1'b0, 1'b1, 1'b1);
        clk1hz = 1'b0;
        rstN   = 1'b1;
        idle(2);
        checkResetValues("after release");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
        $finish;
    end

endmodule
